int8_mac_seq: RTL
=================

Name: int8_mac_seq

Overview:
- Command-driven sequencer that computes an INT8 dot product using the shared int8_mac_unit.
- Accepts one command: length, initial accumulator, clip flag and writeback tags. Then consumes a stream of signed byte operand pairs.
- Issues one MAC8_ACC per pair, feeding each result back as the next accumulator. Optionally issues a final CLIP8.
- Returns a single tagged response. Sits between the CV-X-IF offload decoder and int8_mac_unit.

Parameters:
- XLEN, 32, datapath and accumulator width.
- LEN_W, 8, width of the command length field (max 2^LEN_W-1 pairs).
- TIMEOUT, 16, cycles to wait for mac_valid_i before flagging an error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_len_i  in  LEN_W  number of operand pairs.
- cmd_acc_i  in  XLEN  initial accumulator (signed).
- cmd_clip_i  in  1  apply CLIP8 to the final sum.
- cmd_rd_addr_i  in  5  destination register tag.
- cmd_hartid_i  in  2  hart tag.
- cmd_id_i  in  3  instruction id tag.
- op_valid_i  in  1  operand pair valid.
- op_ready_o  out  1  operand pair consumed when valid&ready.
- op_a_i  in  8  signed operand a.
- op_b_i  in  8  signed operand b.
- mac_issue_o  out  1  one-cycle issue strobe to the MAC unit.
- mac_opcode_o  out  opcode_t  MAC8_ACC, CLIP8, or ILLEGAL when idle.
- mac_rs1_o  out  XLEN  sign-extended a, or the accumulator for CLIP8.
- mac_rs2_o  out  XLEN  sign-extended b, or 0 for CLIP8.
- mac_rd_o  out  XLEN  current accumulator.
- mac_result_i  in  XLEN  MAC unit result.
- mac_valid_i  in  1  MAC unit result valid.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_result_o  out  XLEN  final sum, clipped if requested.
- rsp_rd_addr_o  out  5  echoed tag.
- rsp_hartid_o  out  2  echoed tag.
- rsp_id_o  out  3  echoed tag.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  timeout flag.

Behaviour:
- Reset values: all outputs 0, except mac_opcode_o=ILLEGAL. State=IDLE; accumulator, counter and tags cleared.
- FSM states: IDLE, ISSUE, WAIT, CLIP, CLIP_WAIT, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On handshake, latch len/acc/clip/tags, clear count, clear err_o.
  - Next state: ISSUE if len>0; else CLIP if clip; else RESP.
- ISSUE:
  - op_ready_o=1.
  - On op_valid_i, in the same cycle: mac_issue_o=1, opcode=MAC8_ACC, rs1=sext(a), rs2=sext(b), rd=acc. Go to WAIT.
  - If op_valid_i is low, stay in ISSUE with no issue.
- WAIT:
  - op_ready_o=0, mac_issue_o=0.
  - On mac_valid_i: acc<=mac_result_i, count++.
  - If count+1==len: go to CLIP if clip, else RESP. Otherwise return to ISSUE.
  - Minimum 2 cycles per pair with a 1-cycle MAC. Only one operation is ever in flight.
- CLIP:
  - Single-cycle issue: opcode=CLIP8, rs1=acc, rs2=0, rd=acc. Go to CLIP_WAIT.
- CLIP_WAIT:
  - On mac_valid_i, acc<=mac_result_i. Go to RESP.
- RESP:
  - rsp_valid_o=1 with acc and tags.
  - Hold all response fields stable until rsp_ready_i, then go to IDLE.
  - cmd_ready_o=0 throughout, so a new command is accepted at earliest the cycle after the response handshake.
- Arithmetic: operands sign-extended 8->XLEN. The accumulator is whatever the MAC returns; two's-complement wrap at XLEN is not checked here.
- mac_opcode_o and mac_rs*/mac_rd_o are don't-care when mac_issue_o=0. mac_opcode_o is driven ILLEGAL in IDLE.
- mac_valid_i outside WAIT or CLIP_WAIT is ignored and does not alter the accumulator.
- Timeout: in WAIT or CLIP_WAIT, a cycle counter runs.
  - On reaching TIMEOUT without mac_valid_i: err_o=1 (sticky until next command accepted).
  - Go to RESP with the current accumulator. The response is still delivered.
- len=0: no MAC8_ACC is issued. The result is cmd_acc_i, or its CLIP8 value if clip=1.
- Reset mid-operation: return to IDLE next cycle. A pending MAC result arriving after reset is ignored. No response is produced for the aborted command.

Test Plan:
- len=3, acc=0, clip=0, pairs (10,10),(20,5),(3,7) -> exactly 3 MAC8_ACC issues with rd=0,100,200; rsp_result=221; tags echoed; err_o=0.
- len=2, acc=50, clip=1, pairs (100,1),(1,1) -> 2 MAC8_ACC then 1 CLIP8 with rs1=151; rsp_result=127.
- len=1, acc=0, pair (-128,-128) -> 16384. Same command with clip=1 -> 127. Also pair (-5,3), acc=0 -> -15.
- len=0, acc=-200, clip=1 -> no MAC8_ACC issued, one CLIP8, rsp_result=-128. len=0, clip=0, acc=42 -> no issues, rsp_result=42.
- Backpressure:
  - op_valid_i gapped 3 cycles between pairs -> no extra issues; correct sum.
  - rsp_ready_i low 5 cycles -> rsp fields stable, cmd_ready_o=0, busy_o=1.
- Error and reset:
  - MAC model withholds mac_valid_i -> err_o rises TIMEOUT cycles after issue; response delivered.
  - rst_i asserted in WAIT mid len=4 command -> IDLE next cycle, all outputs reset; late mac_valid_i ignored.
  - A new command then completes correctly.

Source files
------------

// File: rtl/int8_mac_seq.sv
// int8_mac_seq: command-driven INT8 dot-product sequencer feeding a shared int8_mac_unit
package int8_mac_seq_pkg;
  typedef enum logic [1:0] {MAC8_ACC = 2'd0, CLIP8 = 2'd1, ILLEGAL = 2'd3} opcode_t;
endpackage

module int8_mac_seq
  import int8_mac_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [XLEN-1:0]  cmd_acc_i,
  input  logic             cmd_clip_i,
  input  logic [4:0]       cmd_rd_addr_i,
  input  logic [1:0]       cmd_hartid_i,
  input  logic [2:0]       cmd_id_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       op_a_i,
  input  logic [7:0]       op_b_i,
  output logic             mac_issue_o,
  output opcode_t          mac_opcode_o,
  output logic [XLEN-1:0]  mac_rs1_o,
  output logic [XLEN-1:0]  mac_rs2_o,
  output logic [XLEN-1:0]  mac_rd_o,
  input  logic [XLEN-1:0]  mac_result_i,
  input  logic             mac_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_result_o,
  output logic [4:0]       rsp_rd_addr_o,
  output logic [1:0]       rsp_hartid_o,
  output logic [2:0]       rsp_id_o,
  output logic             busy_o,
  output logic             err_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLIP, CLIP_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0] tag_q, tag_d;
  logic clip_q, clip_d, err_q, err_d;
  logic issue_op, tmo_hit, last;
  assign issue_op = state_q == ISSUE && op_valid_i;
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign last = cnt_q == len_q - LEN_W'(1);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    len_d = len_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    tag_d = tag_q;
    clip_d = clip_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        len_d = cmd_len_i;
        acc_d = cmd_acc_i;
        clip_d = cmd_clip_i;
        tag_d = {cmd_rd_addr_i, cmd_hartid_i, cmd_id_i};
        cnt_d = '0;
        err_d = 1'b0;
        state_d = cmd_len_i != '0 ? ISSUE : cmd_clip_i ? CLIP : RESP;
      end
      ISSUE: if (op_valid_i) begin
        tmo_d = '0;
        state_d = WAIT;
      end
      WAIT, CLIP_WAIT: if (mac_valid_i) begin
        acc_d = mac_result_i;
        cnt_d = cnt_q + LEN_W'(1);
        state_d = state_q == CLIP_WAIT ? RESP : !last ? ISSUE : clip_q ? CLIP : RESP;
      end else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = RESP;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
      CLIP: begin
        tmo_d = '0;
        state_d = CLIP_WAIT;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      tag_q <= '0;
      clip_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      tag_q <= tag_d;
      clip_q <= clip_d;
      err_q <= err_d;
    end
  end
  assign cmd_ready_o = state_q == IDLE;
  assign op_ready_o = state_q == ISSUE;
  assign mac_issue_o = issue_op || state_q == CLIP;
  assign mac_opcode_o = state_q == CLIP ? CLIP8 : issue_op ? MAC8_ACC : ILLEGAL;
  assign mac_rs1_o = issue_op ? {{(XLEN-8){op_a_i[7]}}, op_a_i} : state_q == CLIP ? acc_q : '0;
  assign mac_rs2_o = issue_op ? {{(XLEN-8){op_b_i[7]}}, op_b_i} : '0;
  assign mac_rd_o = mac_issue_o ? acc_q : '0;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_result_o = rsp_valid_o ? acc_q : '0;
  assign {rsp_rd_addr_o, rsp_hartid_o, rsp_id_o} = rsp_valid_o ? tag_q : '0;
  assign busy_o = state_q != IDLE;
  assign err_o = err_q;
endmodule
